// File: rtl/melody_pkg.sv
// Shared encodings for the melody sequencer: FSM states, reserved field values, entry layout.
// Score entries are packed {dur, note} with the note in the low bits.
package melody_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_PLAY  = 2'd3;

  localparam int NOTE_REST = 0;
  localparam int DUR_END   = 0;

  // The dur field starts at NOTE_LSB + NOTE_W.
  localparam int NOTE_LSB  = 0;
endpackage

// File: rtl/melody_sequencer_if.sv
// Control, score-write and tone-generator signals of the melody sequencer.
// master = controller/bench side, slave = sequencer side.
interface melody_sequencer_if #(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 4,
  parameter int ADDR_W = 5
);
  logic                    start;
  logic                    stop;
  logic                    loop;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DUR_W+NOTE_W-1:0] wr_data;
  logic [NOTE_W-1:0]       note;
  logic                    speak;
  logic                    busy;
  logic                    done;
  logic [ADDR_W-1:0]       pos;

  modport master (
    output start, stop, loop, wr_en, wr_addr, wr_data,
    input  note, speak, busy, done, pos
  );

  modport slave (
    input  start, stop, loop, wr_en, wr_addr, wr_data,
    output note, speak, busy, done, pos
  );
endinterface

// File: rtl/melody_sequencer_score_ram.sv
// Score storage: 1W/1R synchronous RAM, one-cycle registered read, read-old-data on collision.
// No reset on the array; contents survive nrst.
module score_ram #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/melody_sequencer.sv
// Score player: FETCH/LOAD/PLAY walk over score_ram, each entry lasting dur*TICK_DIV clocks.
// Two-clock gap between entries; start/stop act on the next clock, stop has priority.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_DIV = 312500,
  parameter int NOTE_W   = 4,
  parameter int DUR_W    = 4,
  parameter int ADDR_W   = 5
) (
  input logic               clk,
  input logic               nrst,
  melody_sequencer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int EW = DUR_W + NOTE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              speak_q, speak_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic [PW-1:0]     presc_q, presc_d;

  logic [EW-1:0]     rd_data;
  logic [NOTE_W-1:0] ent_note;
  logic [DUR_W-1:0]  ent_dur;
  logic              tick;
  logic              eos;

  score_ram #(.AW(ADDR_W), .DW(EW)) u_ram (
    .clk       (clk),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (state_q == ST_FETCH),
    .rd_addr_i (pos_q),
    .rd_data_o (rd_data)
  );

  assign ent_note = rd_data[NOTE_LSB +: NOTE_W];
  assign ent_dur  = rd_data[NOTE_LSB + NOTE_W +: DUR_W];
  assign tick     = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    speak_d = speak_q;
    done_d  = 1'b0;
    pos_d   = pos_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    eos     = 1'b0;

    case (state_q)
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (ent_dur == DUR_W'(DUR_END)) begin
          eos = 1'b1;
        end else begin
          note_d  = ent_note;
          speak_d = (ent_note != NOTE_W'(NOTE_REST));
          rem_d   = ent_dur;
          presc_d = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            // The last entry ends the score rather than wrapping pos.
            if (pos_q == LAST_ADDR) begin
              eos = 1'b1;
            end else begin
              pos_d   = pos_q + ADDR_W'(1);
              speak_d = 1'b0;
              state_d = ST_FETCH;
            end
          end
        end
      end
      default: ;
    endcase

    if (eos) begin
      if (bus.loop) begin
        pos_d   = '0;
        speak_d = 1'b0;
        state_d = ST_FETCH;
      end else begin
        note_d  = '0;
        speak_d = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    if (bus.stop) begin
      note_d  = '0;
      speak_d = 1'b0;
      done_d  = 1'b0;
      state_d = ST_IDLE;
    end else if (bus.start) begin
      note_d  = '0;
      speak_d = 1'b0;
      done_d  = 1'b0;
      pos_d   = '0;
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      note_q  <= '0;
      speak_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pos_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      speak_q <= speak_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

  assign bus.note  = note_q;
  assign bus.speak = speak_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.pos   = pos_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with TICK_DIV=4: directed scores plus randomized control and writes,
// all checked each cycle against a timeline model of the score.
module tb_melody_sequencer;
  localparam int TD    = 4;
  localparam int NW    = 4;
  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  melody_sequencer_if #(.NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW)) bif ();

  melody_sequencer #(.TICK_DIV(TD), .NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an entry of duration d occupies a 2-clock fetch gap then d*TD playing clocks.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_ent   = '0;
  bit         m_busy  = 0;
  bit         m_speak = 0;
  bit         m_done  = 0;
  bit         m_eos   = 0;
  int         m_note  = 0;
  int         m_pos   = 0;
  int         m_gap   = 0;
  int         m_left  = 0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy = 0; m_speak = 0; m_done = 0; m_note = 0; m_pos = 0;
    end else begin
      m_eos  = 0;
      m_done = 0;
      if (m_busy) begin
        if (m_gap == 2) begin
          m_ent = m_mem[m_pos];
          m_gap = 1;
        end else if (m_gap == 1) begin
          if (m_ent[7:4] == 4'd0) m_eos = 1;
          else begin
            m_note  = int'(m_ent[3:0]);
            m_speak = (m_note != 0);
            m_left  = int'(m_ent[7:4]) * TD;
            m_gap   = 0;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_pos == DEPTH - 1) m_eos = 1;
            else begin m_pos++; m_gap = 2; m_speak = 0; end
          end
        end
      end
      if (m_eos) begin
        if (bif.loop) begin m_pos = 0; m_gap = 2; m_speak = 0; end
        else begin m_busy = 0; m_done = 1; m_note = 0; m_speak = 0; end
      end
      if (bif.stop) begin
        m_busy = 0; m_note = 0; m_speak = 0; m_done = 0;
      end else if (bif.start) begin
        m_busy = 1; m_pos = 0; m_gap = 2; m_note = 0; m_speak = 0; m_done = 0;
      end
      if (bif.wr_en) m_mem[bif.wr_addr] = bif.wr_data;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy",  int'(bif.busy),  int'(m_busy));
      chk("model_speak", int'(bif.speak), int'(m_speak));
      chk("model_done",  int'(bif.done),  int'(m_done));
      chk("model_note",  int'(bif.note),  m_note);
      chk("model_pos",   int'(bif.pos),   m_pos);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    bif.wr_en = 1'b1; bif.wr_addr = AW'(a); bif.wr_data = 8'(d);
    @(negedge clk);
    bif.wr_en = 1'b0;
  endtask

  // Returns at the first negedge after the pulse was sampled.
  task automatic pulse(input bit s, input bit p);
    @(negedge clk);
    bif.start = s; bif.stop = p;
    @(negedge clk);
    bif.start = 1'b0; bif.stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!bif.done && n < budget) begin step(1); n++; end
    if (!bif.done) chk(name, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, idx;
    bit wrapped, left0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    bif.start = 0; bif.stop = 0; bif.loop = 0; bif.wr_en = 0; bif.wr_addr = '0; bif.wr_data = '0;
    #1 nrst = 1'b0;
    cmp_en = 1;
    step(3);
    nrst = 1'b1;
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_note", int'(bif.note), 0);
    chk("rst_speak", int'(bif.speak), 0);
    chk("rst_done", int'(bif.done), 0);
    chk("rst_pos", int'(bif.pos), 0);
    // Pre-clear the whole score so nothing is read uninitialised.
    for (int i = 0; i < DEPTH; i++) wr(i, 8'h00);

    // Two notes then end marker.
    wr(0, 8'h24); wr(1, 8'h15); wr(2, 8'h00);
    pulse(1, 0);
    chk("t1_n1_busy", int'(bif.busy), 1);
    chk("t1_n1_speak", int'(bif.speak), 0);
    step(2);
    chk("t1_n3_note", int'(bif.note), 4);
    chk("t1_n3_speak", int'(bif.speak), 1);
    step(7);
    chk("t1_n10_speak", int'(bif.speak), 1);
    step(1);
    chk("t1_gap_speak", int'(bif.speak), 0);
    chk("t1_gap_note", int'(bif.note), 4);
    chk("t1_gap_pos", int'(bif.pos), 1);
    step(2);
    chk("t1_n13_note", int'(bif.note), 5);
    chk("t1_n13_speak", int'(bif.speak), 1);
    step(6);
    chk("t1_done", int'(bif.done), 1);
    chk("t1_end_busy", int'(bif.busy), 0);
    chk("t1_end_note", int'(bif.note), 0);
    step(1);
    chk("t1_done_width", int'(bif.done), 0);

    // Rest entry keeps the speaker off.
    wr(0, 8'h10); wr(1, 8'h13); wr(2, 8'h00);
    pulse(1, 0);
    step(2);
    chk("t2_rest_speak", int'(bif.speak), 0);
    chk("t2_rest_busy", int'(bif.busy), 1);
    step(6);
    chk("t2_n9_note", int'(bif.note), 3);
    chk("t2_n9_speak", int'(bif.speak), 1);
    step(6);
    chk("t2_done", int'(bif.done), 1);

    // Looping score: the end marker restarts at address 0 without done.
    wr(0, 8'h12); wr(1, 8'h00);
    bif.loop = 1'b1;
    pulse(1, 0);
    step(10);
    chk("t3_replay_note", int'(bif.note), 2);
    chk("t3_replay_pos", int'(bif.pos), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(1); if (bif.done) cnt++; end
    chk("t3_loop_no_done", cnt, 0);
    bif.loop = 1'b0;
    wait_done("t3_done_timeout", 20);

    // Full score of one-tick entries: pos must end at the top address.
    for (int i = 0; i < DEPTH; i++) wr(i, 8'h10 | ((i % 15) + 1));
    pulse(1, 0);
    idx = 1; wrapped = 0; left0 = 0;
    while (!bif.done && idx < 400) begin
      step(1); idx++;
      if (bif.pos != 0) left0 = 1;
      if (left0 && bif.busy && bif.pos == 0) wrapped = 1;
    end
    chk("t4_done_cycle", idx, 193);
    chk("t4_end_pos", int'(bif.pos), DEPTH - 1);
    chk("t4_no_wrap", int'(wrapped), 0);

    // stop, stop+start, and restart mid-note.
    wr(0, 8'h37); wr(1, 8'h00);
    pulse(1, 0); step(3);
    pulse(0, 1);
    chk("t5_stop_busy", int'(bif.busy), 0);
    chk("t5_stop_speak", int'(bif.speak), 0);
    chk("t5_stop_note", int'(bif.note), 0);
    chk("t5_stop_done", int'(bif.done), 0);
    pulse(1, 0); step(3);
    pulse(1, 1);
    chk("t5_both_busy", int'(bif.busy), 0);
    pulse(1, 0); step(4);
    pulse(1, 0);
    chk("t5_restart_pos", int'(bif.pos), 0);
    chk("t5_restart_busy", int'(bif.busy), 1);
    chk("t5_restart_speak", int'(bif.speak), 0);
    step(2);
    chk("t5_restart_note", int'(bif.note), 7);

    // Async reset mid-note, replay, then empty score.
    step(2);
    #2 nrst = 1'b0;
    #1;
    chk("t6_arst_speak", int'(bif.speak), 0);
    chk("t6_arst_busy", int'(bif.busy), 0);
    chk("t6_arst_note", int'(bif.note), 0);
    step(2);
    nrst = 1'b1;
    pulse(1, 0); step(2);
    chk("t6_replay_note", int'(bif.note), 7);
    pulse(0, 1);
    wr(0, 8'h00);
    pulse(1, 0);
    chk("t6_empty_n1_done", int'(bif.done), 0);
    step(2);
    chk("t6_empty_done", int'(bif.done), 1);
    chk("t6_empty_speak", int'(bif.speak), 0);

    // Randomized control and score writes, checked by the model every cycle.
    for (int i = 0; i < DEPTH; i++)
      wr(i, (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3))) * 16 + int'($urandom_range(0, 15)));
    pulse(1, 0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bif.start = ($urandom_range(0, 149) == 0);
      bif.stop  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) bif.loop = ~bif.loop;
      bif.wr_en   = ($urandom_range(0, 9) == 0);
      bif.wr_addr = AW'($urandom_range(0, DEPTH - 1));
      bif.wr_data = 8'((($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3)) * 16 + $urandom_range(0, 15));
      if (!bif.busy && $urandom_range(0, 19) == 0) bif.start = 1'b1;
    end
    @(negedge clk);
    bif.start = 0; bif.stop = 0; bif.wr_en = 0;
    step(2);
    cmp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
